// File: rtl/result_display_driver.sv
// result_display_driver
// Displays the arithmetic unit's 8-bit unsigned result, its status flag and
// its operation code on a 4-digit common-anode seven-segment display.
// A sequential double-dabble engine converts the result to BCD. The three
// decimal digits and the op-code digit are time-multiplexed.
//
// Ports:
//   clk     - system clock, rising edge
//   reset_n - asynchronous active-low reset
//   value   - unsigned result to display
//   flag    - status bit; shown on led and on the op-code decimal point
//   select  - operation code 0..3, shown as a digit
//   an      - digit enables, active-low (0 ones, 1 tens, 2 hundreds, 3 op code)
//   seg     - segments {g,f,e,d,c,b,a}, active-low
//   dp      - decimal point, active-low
//   led     - displayed flag, active-high
//   busy    - high while a conversion is in progress
module result_display_driver #(
    parameter int unsigned SCAN_DIV      = 50000,
    parameter bit          BLANK_LEADING = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] value,
    input  logic       flag,
    input  logic [1:0] select,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       led,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONV   = 2'd1,
        ST_UPDATE = 2'd2
    } state_t;

    localparam logic [19:0] PRESC_MAX = 20'(SCAN_DIV - 1);
    localparam logic [6:0]  SEG_BLANK = 7'b1111111;

    // Double-dabble correction for one BCD nibble
    function automatic logic [3:0] add3(input logic [3:0] nib);
        if (nib >= 4'd5) begin
            add3 = nib + 4'd3;
        end else begin
            add3 = nib;
        end
    endfunction

    // One engine step: correct every nibble, then shift the whole register left.
    // The 2-bit hundreds field never reaches 5, so its correction is the identity.
    function automatic logic [17:0] dabble_step(input logic [17:0] sr);
        logic [17:0] adj;
        adj = {sr[17:16], add3(sr[15:12]), add3(sr[11:8]), sr[7:0]};
        dabble_step = {adj[16:0], 1'b0};
    endfunction

    // Active-low glyph for a decimal digit; anything else is blank
    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    glyph = 7'b1000000;
            4'd1:    glyph = 7'b1111001;
            4'd2:    glyph = 7'b0100100;
            4'd3:    glyph = 7'b0110000;
            4'd4:    glyph = 7'b0011001;
            4'd5:    glyph = 7'b0010010;
            4'd6:    glyph = 7'b0000010;
            4'd7:    glyph = 7'b1111000;
            4'd8:    glyph = 7'b0000000;
            4'd9:    glyph = 7'b0010000;
            default: glyph = SEG_BLANK;
        endcase
    endfunction

    state_t      state_r, state_next_s;
    logic        change_s, capture_s, step_s, commit_s;
    logic [7:0]  snap_value_r;
    logic [1:0]  snap_select_r;
    logic        snap_flag_r, snap_valid_r;
    logic [17:0] shift_r;
    logic [2:0]  cnt_r;
    logic [1:0]  disp_hund_r;
    logic [3:0]  disp_tens_r, disp_ones_r;
    logic [1:0]  disp_select_r;
    logic        disp_flag_r;
    logic        busy_r;
    logic [19:0] presc_r;
    logic [1:0]  digit_r;
    logic [3:0]  an_s, an_r;
    logic [6:0]  seg_s, seg_r;
    logic        dp_s, dp_r;

    assign change_s = (snap_valid_r == 1'b0) || (value != snap_value_r) ||
                      (select != snap_select_r) || (flag != snap_flag_r);

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (change_s) begin
                    state_next_s = ST_CONV;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_CONV: begin
                if (cnt_r == 3'd7) begin
                    state_next_s = ST_UPDATE;
                end else begin
                    state_next_s = ST_CONV;
                end
            end
            ST_UPDATE: state_next_s = ST_IDLE;
            default:   state_next_s = ST_IDLE;
        endcase
    end

    // FSM output strobes for the datapath
    always_comb begin
        capture_s = 1'b0;
        step_s    = 1'b0;
        commit_s  = 1'b0;
        case (state_r)
            ST_IDLE:   capture_s = change_s;
            ST_CONV:   step_s    = 1'b1;
            ST_UPDATE: commit_s  = 1'b1;
            default: begin
                capture_s = 1'b0;
                step_s    = 1'b0;
                commit_s  = 1'b0;
            end
        endcase
    end

    // Input snapshot and conversion engine
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snap_value_r  <= 8'd0;
            snap_select_r <= 2'd0;
            snap_flag_r   <= 1'b0;
            snap_valid_r  <= 1'b0;
            shift_r       <= 18'd0;
            cnt_r         <= 3'd0;
        end else if (capture_s) begin
            snap_value_r  <= value;
            snap_select_r <= select;
            snap_flag_r   <= flag;
            shift_r       <= {10'd0, value};
            cnt_r         <= 3'd0;
        end else if (step_s) begin
            shift_r <= dabble_step(shift_r);
            cnt_r   <= cnt_r + 3'd1;
        end else if (commit_s) begin
            snap_valid_r <= 1'b1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Display registers: BCD, select and flag change together, never partially
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            disp_hund_r   <= 2'd0;
            disp_tens_r   <= 4'd0;
            disp_ones_r   <= 4'd0;
            disp_select_r <= 2'd0;
            disp_flag_r   <= 1'b0;
        end else if (commit_s) begin
            disp_hund_r   <= shift_r[17:16];
            disp_tens_r   <= shift_r[15:12];
            disp_ones_r   <= shift_r[11:8];
            disp_select_r <= snap_select_r;
            disp_flag_r   <= snap_flag_r;
        end else begin
            disp_flag_r <= disp_flag_r;
        end
    end

    // busy follows the state being entered, so it is high exactly in CONV/UPDATE
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_r <= 1'b0;
        end else begin
            busy_r <= (state_next_s != ST_IDLE);
        end
    end

    // Scan prescaler and digit index
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_r <= 20'd0;
            digit_r <= 2'd0;
        end else if (presc_r >= PRESC_MAX) begin
            presc_r <= 20'd0;
            digit_r <= digit_r + 2'd1;
        end else begin
            presc_r <= presc_r + 20'd1;
        end
    end

    // Content of the currently selected digit
    always_comb begin
        an_s  = 4'b1111;
        seg_s = SEG_BLANK;
        dp_s  = 1'b1;
        case (digit_r)
            2'd0: begin
                an_s  = 4'b1110;
                seg_s = glyph(disp_ones_r);
            end
            2'd1: begin
                an_s = 4'b1101;
                if (BLANK_LEADING && (disp_hund_r == 2'd0) && (disp_tens_r == 4'd0)) begin
                    seg_s = SEG_BLANK;
                end else begin
                    seg_s = glyph(disp_tens_r);
                end
            end
            2'd2: begin
                an_s = 4'b1011;
                if (BLANK_LEADING && (disp_hund_r == 2'd0)) begin
                    seg_s = SEG_BLANK;
                end else begin
                    seg_s = glyph({2'b00, disp_hund_r});
                end
            end
            2'd3: begin
                an_s  = 4'b0111;
                seg_s = glyph({2'b00, disp_select_r});
                dp_s  = ~disp_flag_r;
            end
            default: begin
                an_s  = 4'b1111;
                seg_s = SEG_BLANK;
                dp_s  = 1'b1;
            end
        endcase
    end

    // Registered display drive
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            an_r  <= 4'b1111;
            seg_r <= SEG_BLANK;
            dp_r  <= 1'b1;
        end else begin
            an_r  <= an_s;
            seg_r <= seg_s;
            dp_r  <= dp_s;
        end
    end

    assign an   = an_r;
    assign seg  = seg_r;
    assign dp   = dp_r;
    assign led  = disp_flag_r;
    assign busy = busy_r;

endmodule

// File: tb/tb_result_display_driver.sv
// Self-checking bench for result_display_driver.
// Three instances share the inputs: main (SCAN_DIV=1, blanking on),
// nb (SCAN_DIV=1, blanking off) and s4 (SCAN_DIV=4, blanking on).
module tb_result_display_driver;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] value = 8'd0;
    logic       flag = 1'b0;
    logic [1:0] select = 2'd0;

    logic [3:0] an0, an1, an2;
    logic [6:0] seg0, seg1, seg2;
    logic       dp0, dp1, dp2, led0, led1, led2, busy0, busy1, busy2;

    int total = 0;
    int bad   = 0;

    localparam logic [6:0] BLANK = 7'b1111111;

    // Expected display vectors {d3,d2,d1,d0,dp[3:0],led}
    logic [32:0] sb_q[$];

    // Trace of one instance, sampled at negedges
    logic [3:0] tr_an[64];
    logic [6:0] tr_seg[64];
    logic       tr_dp[64];
    logic       tr_led[64];
    logic       tr_busy[64];

    always #5 clk = ~clk;

    result_display_driver #(.SCAN_DIV(1), .BLANK_LEADING(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .value(value), .flag(flag), .select(select),
        .an(an0), .seg(seg0), .dp(dp0), .led(led0), .busy(busy0));

    result_display_driver #(.SCAN_DIV(1), .BLANK_LEADING(1'b0)) dut_nb (
        .clk(clk), .reset_n(reset_n), .value(value), .flag(flag), .select(select),
        .an(an1), .seg(seg1), .dp(dp1), .led(led1), .busy(busy1));

    result_display_driver #(.SCAN_DIV(4), .BLANK_LEADING(1'b1)) dut_s4 (
        .clk(clk), .reset_n(reset_n), .value(value), .flag(flag), .select(select),
        .an(an2), .seg(seg2), .dp(dp2), .led(led2), .busy(busy2));

    function automatic logic [6:0] gl(input int d);
        case (d)
            0: gl = 7'b1000000;
            1: gl = 7'b1111001;
            2: gl = 7'b0100100;
            3: gl = 7'b0110000;
            4: gl = 7'b0011001;
            5: gl = 7'b0010010;
            6: gl = 7'b0000010;
            7: gl = 7'b1111000;
            8: gl = 7'b0000000;
            9: gl = 7'b0010000;
            default: gl = BLANK;
        endcase
    endfunction

    function automatic logic [32:0] model(input int v, input int s, input bit f, input bit bl);
        int h, t, o;
        logic [6:0] d0, d1, d2, d3;
        h  = v / 100;
        t  = (v / 10) % 10;
        o  = v % 10;
        d0 = gl(o);
        d1 = (bl && h == 0 && t == 0) ? BLANK : gl(t);
        d2 = (bl && h == 0) ? BLANK : gl(h);
        d3 = gl(s);
        return {d3, d2, d1, d0, ~f, 3'b111, f};
    endfunction

    task automatic record(input int which, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            case (which)
                0: begin tr_an[i] = an0; tr_seg[i] = seg0; tr_dp[i] = dp0; tr_led[i] = led0; tr_busy[i] = busy0; end
                1: begin tr_an[i] = an1; tr_seg[i] = seg1; tr_dp[i] = dp1; tr_led[i] = led1; tr_busy[i] = busy1; end
                default: begin tr_an[i] = an2; tr_seg[i] = seg2; tr_dp[i] = dp2; tr_led[i] = led2; tr_busy[i] = busy2; end
            endcase
        end
    endtask

    task automatic busy_stats(input int from, input int n, output int first, output int len);
        first = -1;
        len   = 0;
        for (int i = from; i < n && first < 0; i++)
            if (tr_busy[i] === 1'b1) first = i;
        if (first >= 0)
            for (int i = first; i < n && tr_busy[i] === 1'b1; i++) len++;
    endtask

    task automatic decode(input int start, output logic [32:0] obs, output int bad_an);
        logic [27:0] g;
        logic [3:0]  p;
        int idx;
        g = '0;
        p = '0;
        bad_an = 0;
        for (int i = 0; i < 4; i++) begin
            idx = start + i;
            case (tr_an[idx])
                4'b1110: begin g[6:0]   = tr_seg[idx]; p[0] = tr_dp[idx]; end
                4'b1101: begin g[13:7]  = tr_seg[idx]; p[1] = tr_dp[idx]; end
                4'b1011: begin g[20:14] = tr_seg[idx]; p[2] = tr_dp[idx]; end
                4'b0111: begin g[27:21] = tr_seg[idx]; p[3] = tr_dp[idx]; end
                default: bad_an++;
            endcase
        end
        obs = {g, p, tr_led[start]};
    endtask

    task automatic test_reset;
        int first, len, ban;
        logic [32:0] obs, exp_v;
        reset_n = 1'b0; value = 8'd0; select = 2'd0; flag = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (an0 !== 4'b1111) begin bad++; $display("FAIL reset_an got=%b exp=1111", an0); end
        total++; if (seg0 !== BLANK) begin bad++; $display("FAIL reset_seg got=%b exp=%b", seg0, BLANK); end
        total++; if (dp0 !== 1'b1) begin bad++; $display("FAIL reset_dp got=%b exp=1", dp0); end
        total++; if (led0 !== 1'b0) begin bad++; $display("FAIL reset_led got=%b exp=0", led0); end
        total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy0); end
        sb_q.push_back(model(0, 0, 1'b0, 1'b1));
        reset_n = 1'b1;
        record(0, 16);
        busy_stats(0, 16, first, len);
        total++; if (first != 0 || len != 9) begin bad++; $display("FAIL reset_busy_pulse got first=%0d len=%0d exp first=0 len=9", first, len); end
        decode(first + len + 1, obs, ban);
        exp_v = sb_q.pop_front();
        total++; if (ban != 0) begin bad++; $display("FAIL reset_an_scan got bad_an=%0d exp=0", ban); end
        total++; if (obs !== exp_v) begin bad++; $display("FAIL reset_display got=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_blank;
        int first, len, ban;
        logic [32:0] obs, exp_v;
        value = 8'd7; select = 2'd0; flag = 1'b0;
        sb_q.push_back(model(7, 0, 1'b0, 1'b1));
        sb_q.push_back(model(7, 0, 1'b0, 1'b0));
        record(0, 16);
        busy_stats(0, 16, first, len);
        total++; if (first != 0 || len != 9) begin bad++; $display("FAIL blank_busy_pulse got first=%0d len=%0d exp first=0 len=9", first, len); end
        decode(first + len + 1, obs, ban);
        exp_v = sb_q.pop_front();
        total++; if (obs !== exp_v) begin bad++; $display("FAIL blank_on_display got=%h exp=%h", obs, exp_v); end
        record(1, 4);
        decode(0, obs, ban);
        exp_v = sb_q.pop_front();
        total++; if (obs !== exp_v) begin bad++; $display("FAIL blank_off_display got=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_back_to_back;
        int f1, l1, f2, l2, ban, fall1, fall2, k, nbad, first_bad;
        logic [32:0] obs, exp_a, exp_b, old_m, cur;
        old_m = model(7, 0, 1'b0, 1'b1);
        value = 8'd100; select = 2'd1; flag = 1'b0;
        sb_q.push_back(model(100, 1, 1'b0, 1'b1));
        sb_q.push_back(model(42, 1, 1'b0, 1'b1));
        fork
            record(0, 40);
            begin
                repeat (4) @(negedge clk);
                value = 8'd42;
            end
        join
        busy_stats(0, 40, f1, l1);
        total++; if (f1 != 0 || l1 != 9) begin bad++; $display("FAIL b2b_pulse1 got first=%0d len=%0d exp first=0 len=9", f1, l1); end
        fall1 = f1 + l1;
        busy_stats(fall1, 40, f2, l2);
        total++; if (f2 != fall1 + 1 || l2 != 9) begin bad++; $display("FAIL b2b_pulse2 got first=%0d len=%0d exp first=%0d len=9", f2, l2, fall1 + 1); end
        fall2 = f2 + l2;
        exp_a = sb_q.pop_front();
        exp_b = sb_q.pop_front();
        decode(fall1 + 1, obs, ban);
        total++; if (obs !== exp_a) begin bad++; $display("FAIL b2b_first_display got=%h exp=%h", obs, exp_a); end
        decode(fall2 + 1, obs, ban);
        total++; if (obs !== exp_b) begin bad++; $display("FAIL b2b_second_display got=%h exp=%h", obs, exp_b); end
        // Every sample must show exactly the display expected for its phase
        nbad = 0;
        first_bad = -1;
        for (int i = 0; i <= fall2 + 4 && i < 40; i++) begin
            cur = (i <= fall1) ? old_m : ((i <= fall2) ? exp_a : exp_b);
            case (tr_an[i])
                4'b1110: k = 0;
                4'b1101: k = 1;
                4'b1011: k = 2;
                4'b0111: k = 3;
                default: k = -1;
            endcase
            if (k < 0 || tr_seg[i] !== cur[5 + 7 * k +: 7] || tr_dp[i] !== cur[1 + k]) begin
                nbad++;
                if (first_bad < 0) first_bad = i;
            end
        end
        total++; if (nbad != 0) begin bad++; $display("FAIL b2b_no_other_value got bad_samples=%0d first_at=%0d exp=0", nbad, first_bad); end
    endtask

    task automatic test_full_scale;
        int first, len, ban;
        logic [32:0] obs, exp_v;
        value = 8'hFF; select = 2'd2; flag = 1'b1;
        sb_q.push_back(model(255, 2, 1'b1, 1'b1));
        record(0, 16);
        busy_stats(0, 16, first, len);
        total++; if (first != 0 || len != 9) begin bad++; $display("FAIL full_busy_pulse got first=%0d len=%0d exp first=0 len=9", first, len); end
        decode(first + len + 1, obs, ban);
        exp_v = sb_q.pop_front();
        total++; if (obs !== exp_v) begin bad++; $display("FAIL full_display got=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_reset_mid_conv;
        int first, len, ban;
        logic [32:0] obs, exp_v;
        value = 8'd200; select = 2'd3; flag = 1'b0;
        repeat (4) @(negedge clk);
        total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL midrst_busy_before got=%b exp=1", busy0); end
        #1 reset_n = 1'b0;
        #1;
        total++; if (an0 !== 4'b1111) begin bad++; $display("FAIL midrst_an got=%b exp=1111", an0); end
        total++; if (seg0 !== BLANK) begin bad++; $display("FAIL midrst_seg got=%b exp=%b", seg0, BLANK); end
        total++; if (led0 !== 1'b0) begin bad++; $display("FAIL midrst_led got=%b exp=0", led0); end
        total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", busy0); end
        repeat (2) @(negedge clk);
        sb_q.push_back(model(200, 3, 1'b0, 1'b1));
        reset_n = 1'b1;
        record(0, 16);
        busy_stats(0, 16, first, len);
        total++; if (first != 0 || len != 9) begin bad++; $display("FAIL midrst_busy_pulse got first=%0d len=%0d exp first=0 len=9", first, len); end
        decode(first + len + 1, obs, ban);
        exp_v = sb_q.pop_front();
        total++; if (obs !== exp_v) begin bad++; $display("FAIL midrst_display got=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_scan;
        int i0, pos, len;
        logic [3:0] pat, nxt;
        record(2, 30);
        i0 = -1;
        for (int i = 1; i < 30 && i0 < 0; i++)
            if (tr_an[i] !== tr_an[i - 1]) i0 = i;
        total++;
        if (i0 < 1 || i0 > 4) begin
            bad++; $display("FAIL scan_first_step got index=%0d exp=1..4", i0);
        end else begin
            pos = i0;
            total++;
            if (!(tr_an[pos] inside {4'b1110, 4'b1101, 4'b1011, 4'b0111})) begin
                bad++; $display("FAIL scan_pattern got=%b exp=one low bit", tr_an[pos]);
            end
            for (int r = 0; r < 5; r++) begin
                pat = tr_an[pos];
                len = 0;
                for (int j = pos; j < 30 && tr_an[j] === pat; j++) len++;
                pos = pos + len;
                total++; if (len != 4) begin bad++; $display("FAIL scan_hold run=%0d an=%b got=%0d exp=4", r, pat, len); end
                nxt = (pos < 30) ? tr_an[pos] : 4'bxxxx;
                total++; if (nxt !== {pat[2:0], pat[3]}) begin bad++; $display("FAIL scan_order run=%0d got=%b exp=%b", r, nxt, {pat[2:0], pat[3]}); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_blank();
        test_back_to_back();
        test_full_scale();
        test_reset_mid_conv();
        test_scan();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
